fir_input_pacer: RTL and testbench

- Sample-pacing buffer placed directly upstream of the 8-bit, 50-tap serial FIR filter.
- Accepts bursty samples from the ADC/source side with a ready/valid handshake and buffers them in a FIFO.
- Releases exactly one sample to the filter and then waits for the filter's output_valid before releasing the next, so the serial filter never receives a sample mid-computation.

---
 rtl/fir_input_pacer.sv | 207 ++++++++++++++++++++
 tb/tb_fir_input_pacer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_input_pacer.sv
// -----------------------------------------------------------------------------
// fir_input_pacer
//
// Sample-pacing buffer in front of a serial FIR filter. Bursty source samples
// are absorbed by a small FIFO. The pacer releases one sample at a time and
// will not release the next one until the filter reports that the current
// computation has finished. This guarantees the filter never sees a new sample
// while it is still working on the previous one.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   in_data       sample from the source
//   in_valid      source holds a valid sample
//   in_ready      FIFO can accept a sample (not full)
//   fir_in        sample presented to the filter; held between issues
//   fir_in_valid  one-cycle pulse telling the filter a new sample is present
//   fir_out_valid filter has finished the current computation
//   level         FIFO occupancy, 0..DEPTH
//   busy          a sample has been issued and its result is still pending
//   overflow      sticky: source offered a sample while in_ready was low
//   clr_ovf       synchronous clear of overflow (a new error in the same
//                 cycle takes priority)
// -----------------------------------------------------------------------------
module fir_input_pacer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] fir_in,
  output logic             fir_in_valid,
  input  logic             fir_out_valid,
  output logic [AW:0]      level,
  output logic             busy,
  output logic             overflow,
  input  logic             clr_ovf
);

  // IDLE  : waiting for a buffered sample
  // ISSUE : the sample was just handed over; fir_in_valid is high this cycle
  // WAIT  : filter is computing; leave only on fir_out_valid
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,        state_d;
  logic [AW-1:0]    wr_ptr_q,       wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q,       rd_ptr_d;
  logic [AW:0]      level_q,        level_d;
  logic [WIDTH-1:0] fir_in_q,       fir_in_d;
  logic             fir_in_valid_q, fir_in_valid_d;
  logic             ovf_q,          ovf_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Full and empty come from the registered level only, so a sample written
  // at one edge cannot be popped before the following edge, and a pop in the
  // same edge as a full-FIFO write does not make room for that write.
  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);
  assign push  = in_valid && !full;

  // ---------------------------------------------------------------------------
  // Sample storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; contents are only ever read at
  // locations covered by level, so clearing it would cost a reset net on
  // every bit for no functional gain.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: pacing FSM, pointers, occupancy and overflow
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    fir_in_d       = fir_in_q;
    fir_in_valid_d = 1'b0;
    ovf_d          = ovf_q;
    pop            = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A stray fir_out_valid here is ignored: nothing is outstanding.
        if (!empty) begin
          pop            = 1'b1;
          fir_in_d       = mem_q[rd_ptr_q];
          rd_ptr_d       = rd_ptr_q + PTR_ONE;
          fir_in_valid_d = 1'b1;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Unconditional single cycle so the valid pulse is exactly one wide.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Returning to IDLE costs one edge, so the next pop lands no earlier
        // than the edge after fir_out_valid.
        if (fir_out_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // A fresh error wins over a clear requested in the same cycle.
    if (in_valid && !full) begin
      ovf_d = ovf_q && !clr_ovf;
    end else if (in_valid) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      fir_in_q       <= '0;
      fir_in_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      fir_in_q       <= fir_in_d;
      fir_in_valid_q <= fir_in_valid_d;
      ovf_q          <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready     = !full;
  assign fir_in       = fir_in_q;
  assign fir_in_valid = fir_in_valid_q;
  assign level        = level_q;
  assign busy         = (state_q == S_WAIT);
  assign overflow     = ovf_q;

  // ---------------------------------------------------------------------------
  // Design invariants
  // ---------------------------------------------------------------------------
  a_level_bounded: assert property (
    @(posedge clk) disable iff (!rst) level_q <= FULL_LEVEL
  );

  a_valid_single_cycle: assert property (
    @(posedge clk) disable iff (!rst) fir_in_valid_q |=> !fir_in_valid_q
  );

  a_no_pop_while_pending: assert property (
    @(posedge clk) disable iff (!rst) (state_q != S_IDLE) |-> !pop
  );

endmodule

// File: tb/tb_fir_input_pacer.sv
// -----------------------------------------------------------------------------
// tb_fir_input_pacer
//
// Self-checking bench for fir_input_pacer. A behavioural model (a sample queue
// plus an "outstanding result" flag) predicts every output on every cycle.
// A small filter stand-in answers each issued sample with fir_out_valid after
// a programmable latency. Directed scenarios add literal expectations, then a
// randomized phase exercises bursts, stalls, overflow and stray results.
// -----------------------------------------------------------------------------
module tb_fir_input_pacer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             clr_ovf = 1'b0;
  logic             fov_stub = 1'b0;
  logic             fov_spur = 1'b0;
  logic             fir_out_valid;
  logic             in_ready;
  logic [WIDTH-1:0] fir_in;
  logic             fir_in_valid;
  logic [AW:0]      level;
  logic             busy;
  logic             overflow;

  assign fir_out_valid = fov_stub | fov_spur;

  fir_input_pacer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fir_in       (fir_in),
    .fir_in_valid (fir_in_valid),
    .fir_out_valid(fir_out_valid),
    .level        (level),
    .busy         (busy),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mq[$];         // samples accepted, not yet handed over
  bit               m_out   = 0;   // a sample was handed over, result pending
  bit               m_pulse = 0;   // hand-over happened at the last edge
  logic [WIDTH-1:0] m_fir   = '0;
  bit               m_ovf   = 0;

  always @(posedge clk or negedge rst) begin : model
    bit can_take;
    bit do_pop;
    if (!rst) begin
      mq.delete();
      m_out   = 0;
      m_pulse = 0;
      m_fir   = '0;
      m_ovf   = 0;
    end else begin
      can_take = (mq.size() < DEPTH);
      do_pop   = !m_out && (mq.size() > 0);
      if (in_valid && !can_take) m_ovf = 1;
      else if (clr_ovf)          m_ovf = 0;
      // The result only counts once the hand-over cycle is over.
      if (m_out && !m_pulse && fir_out_valid) m_out = 0;
      m_pulse = do_pop;
      if (do_pop) begin
        m_fir = mq.pop_front();
        m_out = 1;
      end
      if (in_valid && can_take) mq.push_back(in_data);
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle-by-cycle comparison against the model
  // ---------------------------------------------------------------------------
  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_in_ready",     in_ready,     mq.size() < DEPTH);
      check("cyc_level",        level,        mq.size());
      check("cyc_fir_in",       fir_in,       m_fir);
      check("cyc_fir_in_valid", fir_in_valid, m_pulse);
      check("cyc_busy",         busy,         m_out && !m_pulse);
      check("cyc_overflow",     overflow,     m_ovf);
    end
  end

  // Every cycle with fir_in_valid high records the presented sample.
  logic [WIDTH-1:0] issued[$];
  always @(negedge clk) begin
    if (rst && fir_in_valid) issued.push_back(fir_in);
  end

  // ---------------------------------------------------------------------------
  // Filter stand-in: answers each issue after filt_lat cycles (0 = stalled)
  // ---------------------------------------------------------------------------
  int filt_lat = 0;
  bit lat_rand = 0;
  int cnt      = 0;

  always @(posedge clk) begin
    #1;
    fov_stub = 1'b0;
    if (!rst) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) fov_stub = 1'b1;
      end
      if (fir_in_valid) cnt = lat_rand ? int'($urandom_range(1, 6)) : filt_lat;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge; return at the next one)
  // ---------------------------------------------------------------------------
  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit c, input bit s);
    in_valid = v;
    in_data  = d;
    clr_ovf  = c;
    fov_spur = s;
    @(negedge clk);
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    fov_spur = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (n < budget && !(level == 0 && !busy && !fir_in_valid)) begin
      drive(0, '0, 0, 0);
      n++;
    end
    check({tag, "_drained_level"}, level, 0);
    check({tag, "_drained_busy"},  busy,  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [WIDTH-1:0] exp_seq[$];

  initial begin
    int n;

    // ---- Reset values ------------------------------------------------------
    repeat (3) @(negedge clk);
    check("rst_in_ready",     in_ready,     1);
    check("rst_level",        level,        0);
    check("rst_fir_in",       fir_in,       0);
    check("rst_fir_in_valid", fir_in_valid, 0);
    check("rst_busy",         busy,         0);
    check("rst_overflow",     overflow,     0);
    rst    = 1'b1;
    cmp_en = 1;

    // ---- 1: single sample, filter answers 50 cycles after issue ------------
    filt_lat = 50;
    drive(1, 8'h5A, 0, 0);
    check("s1_level_after_accept", level, 1);
    check("s1_no_early_valid",     fir_in_valid, 0);
    drive(0, '0, 0, 0);
    check("s1_fir_in_valid", fir_in_valid, 1);
    check("s1_fir_in",       fir_in, 8'h5A);
    check("s1_level_popped", level, 0);
    drive(0, '0, 0, 0);
    check("s1_valid_dropped", fir_in_valid, 0);
    check("s1_busy",          busy, 1);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      drive(0, '0, 0, 0);
      if (!busy) break;
      n++;
    end
    check("s1_busy_cycles",  n, 50);
    check("s1_issue_count",  issued.size(), 1);
    check("s1_fir_in_held",  fir_in, 8'h5A);

    // ---- 2: burst into a stalled filter, fill and overflow -----------------
    filt_lat = 0;
    issued.delete();
    for (int i = 1; i <= 17; i++) begin
      drive(1, WIDTH'(i), 0, 0);
      if (i == 16) check("s2_level_15", level, 15);
    end
    check("s2_level_16",  level, 16);
    check("s2_not_ready", in_ready, 0);
    drive(1, 8'h12, 0, 0);
    check("s2_overflow",       overflow, 1);
    check("s2_level_held",     level, 16);
    check("s2_first_issued",   issued.size() > 0 ? issued[0] : 8'hFF, 8'h01);

    // ---- 5: pop and rejected write in one edge; set/clear priority ---------
    drive(0, '0, 1, 0);
    check("s5_ovf_cleared", overflow, 0);
    drive(0, '0, 0, 1);
    check("s5_idle_again", busy, 0);
    drive(1, 8'h13, 0, 0);
    check("s5_level_15",     level, 15);
    check("s5_ovf_on_pop",   overflow, 1);
    check("s5_second_issue", fir_in, 8'h02);
    check("s5_ready_back",   in_ready, 1);
    drive(1, 8'h14, 0, 0);
    check("s5_refill_16", level, 16);
    drive(1, 8'h15, 1, 0);
    check("s5_set_beats_clear", overflow, 1);
    drive(0, '0, 1, 0);
    check("s5_clear_alone", overflow, 0);

    // ---- 3: drain with a 55-cycle filter; order must be preserved ----------
    filt_lat = 55;
    drive(0, '0, 0, 1);
    wait_drain(2000, "s3");
    for (int i = 1; i <= 17; i++) exp_seq.push_back(WIDTH'(i));
    exp_seq.push_back(8'h14);
    check("s3_issue_count", issued.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++) begin
      check($sformatf("s3_order_%0d", i), i < issued.size() ? issued[i] : 8'hFF, exp_seq[i]);
    end

    // ---- 4: stray result while idle and empty ------------------------------
    filt_lat = 5;
    issued.delete();
    drive(0, '0, 0, 1);
    check("s4_no_valid",  fir_in_valid, 0);
    check("s4_not_busy",  busy, 0);
    drive(0, '0, 0, 0);
    check("s4_still_idle", fir_in_valid, 0);
    drive(1, 8'h33, 0, 0);
    drive(0, '0, 0, 0);
    check("s4_valid", fir_in_valid, 1);
    check("s4_data",  fir_in, 8'h33);
    wait_drain(100, "s4");
    check("s4_issue_count", issued.size(), 1);

    // ---- Randomized phase ---------------------------------------------------
    lat_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      bit v;
      v = ($urandom_range(0, 99) < (((i / 500) % 2) == 1 ? 85 : 30));
      drive(v, WIDTH'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0));
    end
    wait_drain(500, "rnd");
    drive(0, '0, 1, 0);
    check("rnd_ovf_cleared", overflow, 0);

    // ---- 6: asynchronous reset mid-WAIT with 7 samples buffered ------------
    lat_rand = 0;
    filt_lat = 0;
    for (int i = 0; i < 8; i++) drive(1, WIDTH'(8'h40 + i), 0, 0);
    check("s6_level_7", level, 7);
    check("s6_busy",    busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("s6_async_in_ready",     in_ready, 1);
    check("s6_async_level",        level, 0);
    check("s6_async_fir_in",       fir_in, 0);
    check("s6_async_fir_in_valid", fir_in_valid, 0);
    check("s6_async_busy",         busy, 0);
    check("s6_async_overflow",     overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issued.delete();
    filt_lat = 3;
    drive(1, 8'h7F, 0, 0);
    drive(0, '0, 0, 0);
    check("s6_first_valid", fir_in_valid, 1);
    check("s6_first_data",  fir_in, 8'h7F);
    wait_drain(100, "s6");
    check("s6_issue_count", issued.size(), 1);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
